// File: rtl/rv32i_decode_stage.sv
// RV32I decode pipeline stage: combinational decode of the full base set, registered into a
// valid/ready output stage with an optional two-entry skid buffer, flush and illegal counter.
module rv32i_decode_stage #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter bit          SKID      = 1'b1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [PC_WIDTH-1:0]  in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_WIDTH-1:0]  out_pc,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [4:0]           out_rd,
  output logic [31:0]          out_imm,
  output logic [3:0]           out_alu_op,
  output logic [1:0]           out_alu_src,
  output logic                 out_reg_write,
  output logic                 out_mem_read,
  output logic                 out_mem_write,
  output logic                 out_branch,
  output logic                 out_jump,
  output logic [1:0]           out_mem_to_reg,
  output logic [2:0]           out_funct3,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] illegal_count
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR   = 4'b0011,
    ALU_XOR = 4'b0100, ALU_SLL = 4'b0101, ALU_SRL = 4'b0110, ALU_SRA  = 4'b0111,
    ALU_SLT = 4'b1000, ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {SRC_RS1_RS2, SRC_RS1_IMM, SRC_PC_IMM, SRC_ZERO_IMM} alu_src_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011, OP_IMM   = 7'b0010011, OP_LOAD = 7'b0000011,
    OP_STORE  = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL  = 7'b1101111,
    OP_JALR   = 7'b1100111, OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111
  } opcode_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [31:0]         imm;
    alu_op_e             alu_op;
    alu_src_e            alu_src;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                jump;
    wb_sel_e             mem_to_reg;
    logic [2:0]          funct3;
    logic                illegal;
  } bundle_t;

  // alt selects SUB over ADD and SRA over SRL; it is ignored for the other funct3 values.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        dec_writes;
  bundle_t     dec;

  assign funct7 = in_instr[31:25];
  assign funct3 = in_instr[14:12];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'h000};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // NOTE: every field gets a default before the case so no path leaves a latch behind.
  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.rd     = in_instr[11:7];
    dec.funct3 = funct3;
    dec.alu_op = ALU_ADD;
    dec_writes = 1'b0;
    case (opcode_e'(in_instr[6:0]))
      OP_R: begin
        dec.alu_op  = alu_from_f3(funct3, funct7[5]);
        dec_writes  = 1'b1;
        dec.illegal = !(funct7 == 7'b0000000 ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OP_IMM: begin
        dec.imm     = imm_i;
        dec.alu_src = SRC_RS1_IMM;
        dec.alu_op  = alu_from_f3(funct3, funct3 == 3'b101 && in_instr[30]);
        dec_writes  = 1'b1;
        if (funct3 == 3'b001)      dec.illegal = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101) dec.illegal = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
      end
      OP_LOAD: begin
        dec.imm        = imm_i;
        dec.alu_src    = SRC_RS1_IMM;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = WB_MEM;
        dec_writes     = 1'b1;
        dec.illegal    = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
      end
      OP_STORE: begin
        dec.imm       = imm_s;
        dec.alu_src   = SRC_RS1_IMM;
        dec.mem_write = 1'b1;
        dec.illegal   = (funct3 >= 3'b011);
      end
      OP_BRANCH: begin
        dec.imm     = imm_b;
        dec.branch  = 1'b1;
        dec.illegal = (funct3 == 3'b010 || funct3 == 3'b011);
        if (funct3[2:1] == 2'b00)      dec.alu_op = ALU_SUB;
        else if (funct3[2:1] == 2'b10) dec.alu_op = ALU_SLT;
        else if (funct3[2:1] == 2'b11) dec.alu_op = ALU_SLTU;
      end
      OP_JAL: begin
        dec.imm        = imm_j;
        dec.jump       = 1'b1;
        dec.alu_src    = SRC_PC_IMM;
        dec.mem_to_reg = WB_PC4;
        dec_writes     = 1'b1;
      end
      OP_JALR: begin
        dec.imm        = imm_i;
        dec.jump       = 1'b1;
        dec.alu_src    = SRC_RS1_IMM;
        dec.mem_to_reg = WB_PC4;
        dec_writes     = 1'b1;
        dec.illegal    = (funct3 != 3'b000);
      end
      OP_LUI: begin
        dec.imm     = imm_u;
        dec.alu_src = SRC_ZERO_IMM;
        dec_writes  = 1'b1;
      end
      OP_AUIPC: begin
        dec.imm     = imm_u;
        dec.alu_src = SRC_PC_IMM;
        dec_writes  = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.reg_write = dec_writes && (dec.rd != 5'd0) && !dec.illegal;
    if (dec.illegal) begin
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
  end

  bundle_t              out_q, out_d, skid_q, skid_d;
  logic                 out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept;

  assign in_ready = SKID ? !skid_valid_q : (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (SKID) begin
      if (!out_valid_q || out_ready) begin
        if (skid_valid_q) begin
          out_d        = skid_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else begin
          out_valid_d = accept;
          if (accept) out_d = dec;
        end
      end else if (accept) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end else if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec.illegal && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: the payload registers are reset as well, since the bundle outputs must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of its peers.
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = out_q.pc;
  assign out_rs1        = out_q.rs1;
  assign out_rs2        = out_q.rs2;
  assign out_rd         = out_q.rd;
  assign out_imm        = out_q.imm;
  assign out_alu_op     = out_q.alu_op;
  assign out_alu_src    = out_q.alu_src;
  assign out_reg_write  = out_q.reg_write;
  assign out_mem_read   = out_q.mem_read;
  assign out_mem_write  = out_q.mem_write;
  assign out_branch     = out_q.branch;
  assign out_jump       = out_q.jump;
  assign out_mem_to_reg = out_q.mem_to_reg;
  assign out_funct3     = out_q.funct3;
  assign out_illegal    = out_q.illegal;
  assign illegal_count  = cnt_q;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage (SKID = 1): directed cases, skid/flush/reset scenarios and random
// traffic, all checked against a rule-level decoder and a two-deep in-flight queue.
module tb_rv32i_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [1:0]  alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic [1:0]  mem_to_reg;
    logic [2:0]  funct3;
    logic        illegal;
  } bundle_t;

  localparam logic [3:0] ALU_OF_F3 [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
  localparam logic [6:0] OPS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_alu_op;
  logic [1:0]  out_alu_src, out_mem_to_reg;
  logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal;
  logic [2:0]  out_funct3;
  logic [15:0] illegal_count;
  bundle_t     dut_b;

  int          n_pass, n_total;
  bundle_t     sb[$];
  logic [15:0] cnt;
  bit          accepted;

  rv32i_decode_stage #(.PC_WIDTH(32), .SKID(1'b1), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_branch(out_branch),
    .out_jump(out_jump), .out_mem_to_reg(out_mem_to_reg), .out_funct3(out_funct3),
    .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  assign dut_b = {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_op, out_alu_src,
                  out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump,
                  out_mem_to_reg, out_funct3, out_illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Decoder written straight from the instruction-set rules.
  function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    bundle_t     b;
    int          f3, f7;
    bit          legal, writes;
    logic [31:0] imm_i;
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    imm_i = $signed(w) >>> 20;
    b = '0;
    b.pc = pc; b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7]; b.funct3 = w[14:12];
    legal = 1'b1; writes = 1'b0;
    case (w[6:0])
      7'h33: begin
        legal    = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        b.alu_op = ALU_OF_F3[f3] + 4'((w[30] && (f3 == 0 || f3 == 5)) ? 1 : 0);
        writes   = 1'b1;
      end
      7'h13: begin
        b.imm = imm_i; b.alu_src = 2'd1; writes = 1'b1;
        b.alu_op = ALU_OF_F3[f3] + 4'((w[30] && f3 == 5) ? 1 : 0);
        if (f3 == 1) legal = (f7 == 0);
        else if (f3 == 5) legal = (f7 == 0 || f7 == 32);
      end
      7'h03: begin
        b.imm = imm_i; b.alu_src = 2'd1; b.mem_read = 1'b1; b.mem_to_reg = 2'd1; writes = 1'b1;
        legal = !(f3 == 3 || f3 == 6 || f3 == 7);
      end
      7'h23: begin
        b.imm = {imm_i[31:5], w[11:7]}; b.alu_src = 2'd1; b.mem_write = 1'b1;
        legal = (f3 < 3);
      end
      7'h63: begin
        b.imm    = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        b.branch = 1'b1;
        b.alu_op = 4'(f3 < 2 ? 1 : f3 < 4 ? 0 : f3 < 6 ? 8 : 9);
        legal    = !(f3 == 2 || f3 == 3);
      end
      7'h6F: begin
        b.imm  = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        b.jump = 1'b1; b.alu_src = 2'd2; b.mem_to_reg = 2'd2; writes = 1'b1;
      end
      7'h67: begin
        b.imm = imm_i; b.jump = 1'b1; b.alu_src = 2'd1; b.mem_to_reg = 2'd2; writes = 1'b1;
        legal = (f3 == 0);
      end
      7'h37: begin b.imm = w & 32'hFFFF_F000; b.alu_src = 2'd3; writes = 1'b1; end
      7'h17: begin b.imm = w & 32'hFFFF_F000; b.alu_src = 2'd2; writes = 1'b1; end
      default: legal = 1'b0;
    endcase
    b.reg_write = writes && (b.rd != 5'd0);
    if (!legal) begin
      b.illegal = 1'b1; b.reg_write = 1'b0; b.mem_read = 1'b0;
      b.mem_write = 1'b0; b.branch = 1'b0; b.jump = 1'b0;
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = OPS[$urandom_range(0, 8)];
    if ($urandom_range(0, 1) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 15) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  // One clock: the stage holds at most two bundles, so in_ready is simply "fewer than two held".
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    bit      exp_ready, acc;
    bundle_t e;
    in_valid = v; in_instr = w; in_pc = pc; out_ready = rdy; flush = fl;
    exp_ready = (sb.size() < 2);
    check("in_ready", 128'(in_ready), 128'(exp_ready));
    check("out_valid", 128'(out_valid), 128'(sb.size() > 0));
    if (sb.size() > 0) check("bundle", 128'(dut_b), 128'(sb[0]));
    acc = v && exp_ready && !fl;
    if (fl) sb.delete();
    else begin
      if (rdy && sb.size() > 0) void'(sb.pop_front());
      if (acc) begin
        e = ref_decode(w, pc);
        sb.push_back(e);
        if (e.illegal && cnt != 16'hFFFF) cnt++;
      end
    end
    accepted = acc;
    @(posedge clk);
    @(negedge clk);
    check("illegal_count", 128'(illegal_count), 128'(cnt));
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_bundle"}, 128'(dut_b), 128'(0));
    check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    check({tag, "_count"}, 128'(illegal_count), 128'(0));
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] pc, input int budget);
    int tries;
    tries = 0;
    accepted = 1'b0;
    while (!accepted && tries < budget) begin
      step(1'b1, w, pc, 1'b1, 1'b0);
      tries++;
    end
    check("send_accepted", 128'(accepted), 128'(1));
  endtask

  initial begin
    logic [15:0] saved_cnt;
    n_pass = 0; n_total = 0; cnt = '0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #12;
    check_zero_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed decode cases, one cycle after each transfer in.
    step(1'b1, 32'h002081B3, 32'h100, 1'b1, 1'b0);
    check("add_alu_op", 128'(out_alu_op), 128'(4'b0000));
    check("add_regs", 128'({out_rs1, out_rs2, out_rd}), 128'({5'd1, 5'd2, 5'd3}));
    check("add_ctl", 128'({out_reg_write, out_alu_src}), 128'({1'b1, 2'b00}));
    step(1'b1, 32'h402081B3, 32'h104, 1'b1, 1'b0);
    check("sub_alu_op", 128'(out_alu_op), 128'(4'b0001));
    step(1'b1, 32'h00812283, 32'h108, 1'b1, 1'b0);
    check("lw_imm", 128'(out_imm), 128'(32'd8));
    check("lw_ctl", 128'({out_mem_read, out_mem_to_reg, out_funct3}), 128'({1'b1, 2'b01, 3'b010}));
    step(1'b1, 32'hFE512E23, 32'h10C, 1'b1, 1'b0);
    check("sw_imm", 128'(out_imm), 128'(32'hFFFF_FFFC));
    check("sw_ctl", 128'({out_mem_write, out_reg_write}), 128'({1'b1, 1'b0}));
    step(1'b1, 32'hFE208CE3, 32'h110, 1'b1, 1'b0);
    check("beq_imm", 128'(out_imm), 128'(32'hFFFF_FFF8));
    check("beq_ctl", 128'({out_branch, out_alu_op}), 128'({1'b1, 4'b0001}));
    step(1'b1, 32'h123453B7, 32'h114, 1'b1, 1'b0);
    check("lui_imm", 128'(out_imm), 128'(32'h1234_5000));
    check("lui_src", 128'(out_alu_src), 128'(2'b11));
    step(1'b1, 32'h00000000, 32'h118, 1'b1, 1'b0);
    check("zero_illegal", 128'(out_illegal), 128'(1));
    check("zero_enables", 128'({out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump}),
          128'(0));
    check("zero_count", 128'(illegal_count), 128'(16'd1));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Skid: four instructions with out_ready low for three cycles.
    step(1'b1, 32'h002081B3, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00812283, 32'h204, 1'b0, 1'b0);
    check("skid_in_ready_low", 128'(in_ready), 128'(0));
    step(1'b1, 32'hFE512E23, 32'h208, 1'b0, 1'b0);
    check("skid_stable_pc", 128'(out_pc), 128'(32'h200));
    send(32'hFE512E23, 32'h208, 8);
    send(32'h123453B7, 32'h20C, 8);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("skid_drained", 128'(out_valid), 128'(0));

    // Flush with both entries held and an illegal word offered.
    step(1'b1, 32'h402081B3, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00812283, 32'h304, 1'b0, 1'b0);
    saved_cnt = illegal_count;
    step(1'b1, 32'h00000000, 32'h308, 1'b0, 1'b1);
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_in_ready", 128'(in_ready), 128'(1));
    check("flush_count", 128'(illegal_count), 128'(saved_cnt));

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);

    // Counter saturation.
    for (int i = 0; i < 65539; i++)
      step(1'b1, (i % 2 == 0) ? 32'h0000_0000 : 32'hFFFF_FFFF, 32'(i), 1'b1, 1'b0);
    check("count_saturated", 128'(illegal_count), 128'(16'hFFFF));

    // Asynchronous reset between clock edges, with both entries held.
    step(1'b1, 32'h002081B3, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h123453B7, 32'h404, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero_state("async_reset");
    sb.delete();
    cnt = '0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 32'h402081B3, 32'h500, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
